// File: rtl/output_snapshot_pingpong_pkg.sv
// Shared definitions for the snapshot ping-pong buffer: per-kind defaults,
// bank-select encoding and the buffer read latency.
package output_snapshot_pingpong_pkg;

  // Defaults per instance kind
  localparam int GATE_N_CH   = 8;
  localparam int GATE_DATA_W = 1;
  localparam int SRC_N_CH    = 8;
  localparam int SRC_DATA_W  = 32;

  // Registered buffer read: data appears one cycle after the address
  localparam int RD_LAT = 1;

  // Bank-select encoding, MSB of the buffer address
  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e bank_flip(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/output_snapshot_pingpong_seq_addr_counter.sv
// Sequential address counter: a start strobe launches a run 0..N-1, one
// step per cycle; busy is high for the whole run, last on the final step.
module output_snapshot_pingpong_seq_addr_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] CNT_LAST = W'(N - 1);

  logic         busy_q, busy_d;
  logic [W-1:0] cnt_q, cnt_d;

  // Next-state: run to CNT_LAST then idle; start is ignored while busy
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  // Counter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign cnt  = cnt_q;
  assign last = busy_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/output_snapshot_pingpong.sv
// Multi-channel output snapshot buffer. A step strobe latches all channels
// into a shadow register, which is serialised into one bank of a two-bank
// RAM. A host request streams the newest committed bank, one word per cycle,
// while the next snapshot may be written into the other bank.
module output_snapshot_pingpong
  import output_snapshot_pingpong_pkg::*;
#(
  parameter int N_CH   = SRC_N_CH,
  parameter int DATA_W = SRC_DATA_W,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sta,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic                     exchange_req,
  input  logic                     clr_flags,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_valid,
  output logic                     out_last,
  output logic                     out_stale,
  output logic                     wr_busy,
  output logic                     rd_busy,
  output logic                     snap_ready,
  output logic                     overrun,
  output logic                     req_drop
);

  localparam int DEPTH = 2 * (2 ** ADDR_W);

  // Engine counters
  logic              wr_cnt_busy, wr_cnt_last;
  logic [ADDR_W-1:0] wr_cnt;
  logic              rd_cnt_busy, rd_cnt_last;
  logic [ADDR_W-1:0] rd_cnt;

  // Control state
  logic [N_CH*DATA_W-1:0] shadow_q, shadow_d;
  bank_e                  wr_bank_q, wr_bank_d;
  bank_e                  commit_bank_q, commit_bank_d;
  bank_e                  rd_bank_q, rd_bank_d;
  logic                   have_snap_q, have_snap_d;
  logic                   snap_ready_q, snap_ready_d;
  logic                   stale_q, stale_d;
  logic                   overrun_q, overrun_d;
  logic                   req_drop_q, req_drop_d;
  logic                   out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]      out_addr_q, out_addr_d;
  logic                   out_last_q, out_last_d;

  // Buffer
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W:0]   wr_addr, rd_addr;

  logic sta_accept, req_accept, rd_busy_int;

  // The read engine stays busy until its last word has left the RAM register
  assign rd_busy_int = rd_cnt_busy || out_valid_q;

  // A write may not start into the bank currently being streamed
  assign sta_accept = sta && !wr_cnt_busy && !(rd_busy_int && (rd_bank_q == wr_bank_q));
  assign req_accept = exchange_req && !rd_busy_int && have_snap_q;

  output_snapshot_pingpong_seq_addr_counter #(.N(N_CH), .W(ADDR_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (sta_accept),
    .busy  (wr_cnt_busy),
    .cnt   (wr_cnt),
    .last  (wr_cnt_last)
  );

  output_snapshot_pingpong_seq_addr_counter #(.N(N_CH), .W(ADDR_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (req_accept),
    .busy  (rd_cnt_busy),
    .cnt   (rd_cnt),
    .last  (rd_cnt_last)
  );

  // Next-state for capture, commit, stream bookkeeping, sticky flags and output stage
  always_comb begin
    shadow_d      = shadow_q;
    wr_bank_d     = wr_bank_q;
    commit_bank_d = commit_bank_q;
    rd_bank_d     = rd_bank_q;
    have_snap_d   = have_snap_q;
    snap_ready_d  = snap_ready_q;
    stale_d       = stale_q;
    overrun_d     = overrun_q;
    req_drop_d    = req_drop_q;

    // Shadow holds the snapshot; it shifts down one word per write so the
    // word to store is always in the low slice
    if (sta_accept) begin
      shadow_d = in_data;
    end else if (wr_cnt_busy) begin
      shadow_d = shadow_q >> DATA_W;
    end

    // A request sees the pre-commit state, so clear before the commit sets
    if (req_accept) begin
      rd_bank_d    = commit_bank_q;
      stale_d      = !snap_ready_q;
      snap_ready_d = 1'b0;
    end

    if (wr_cnt_last) begin
      commit_bank_d = wr_bank_q;
      wr_bank_d     = bank_flip(wr_bank_q);
      have_snap_d   = 1'b1;
      snap_ready_d  = 1'b1;
    end

    // Sticky flags: a same-cycle set overrides the clear
    if (clr_flags) begin
      overrun_d  = 1'b0;
      req_drop_d = 1'b0;
    end
    if (sta && !sta_accept) begin
      overrun_d = 1'b1;
    end
    if (exchange_req && !req_accept) begin
      req_drop_d = 1'b1;
    end

    // Output stage aligned with the registered RAM read
    out_valid_d = rd_cnt_busy;
    out_addr_d  = rd_cnt_busy ? rd_cnt : '0;
    out_last_d  = rd_cnt_last;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      wr_bank_q     <= BANK_0;
      commit_bank_q <= BANK_0;
      rd_bank_q     <= BANK_0;
      have_snap_q   <= 1'b0;
      snap_ready_q  <= 1'b0;
      stale_q       <= 1'b0;
      overrun_q     <= 1'b0;
      req_drop_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      wr_bank_q     <= wr_bank_d;
      commit_bank_q <= commit_bank_d;
      rd_bank_q     <= rd_bank_d;
      have_snap_q   <= have_snap_d;
      snap_ready_q  <= snap_ready_d;
      stale_q       <= stale_d;
      overrun_q     <= overrun_d;
      req_drop_q    <= req_drop_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_last_q    <= out_last_d;
    end
  end

  assign wr_addr = {wr_bank_q, wr_cnt};
  assign rd_addr = {rd_bank_q, rd_cnt};

  // Simple dual-port buffer: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_cnt_busy) begin
      mem[wr_addr] <= shadow_q[DATA_W-1:0];
    end
    rd_data_q <= mem[rd_addr];
  end

  assign out_data   = out_valid_q ? rd_data_q : '0;
  assign out_addr   = out_addr_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_stale  = stale_q && rd_busy_int;
  assign wr_busy    = wr_cnt_busy;
  assign rd_busy    = rd_busy_int;
  assign snap_ready = snap_ready_q;
  assign overrun    = overrun_q;
  assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_output_snapshot_pingpong.sv
// Directed bench for output_snapshot_pingpong (N_CH=8, DATA_W=32).
module tb_output_snapshot_pingpong;

  localparam int N_CH   = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sta;
  logic [N_CH*DATA_W-1:0] in_data;
  logic                   exchange_req;
  logic                   clr_flags;
  logic [DATA_W-1:0]      out_data;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_valid, out_last, out_stale;
  logic                   wr_busy, rd_busy, snap_ready, overrun, req_drop;

  int n_checks = 0;
  int n_errors = 0;

  output_snapshot_pingpong #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sta          (sta),
    .in_data      (in_data),
    .exchange_req (exchange_req),
    .clr_flags    (clr_flags),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_stale    (out_stale),
    .wr_busy      (wr_busy),
    .rd_busy      (rd_busy),
    .snap_ready   (snap_ready),
    .overrun      (overrun),
    .req_drop     (req_drop)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_CH*DATA_W-1:0] make_snap(input logic [31:0] base);
    logic [N_CH*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) v[k*DATA_W +: DATA_W] = base + 32'(k);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Strobe sta for one cycle with channel k = base+k
  task automatic capture(input logic [31:0] base);
    in_data = make_snap(base);
    sta = 1'b1;
    step();
    sta = 1'b0;
    $display("sta base 0x%0h wr_busy=%0b overrun=%0b", base, wr_busy, overrun);
  endtask

  // Request a stream now and check every word of it
  task automatic stream_check(input string tag, input logic [31:0] base,
                              input logic exp_stale, input bit inject_sta);
    exchange_req = 1'b1;
    step();
    exchange_req = 1'b0;
    check_val($sformatf("%s.busy_lat", tag), 64'(rd_busy), 64'd1);
    check_val($sformatf("%s.valid_lat", tag), 64'(out_valid), 64'd0);
    if (inject_sta) begin
      in_data = make_snap(32'hDEAD0000);
      sta = 1'b1;
    end
    for (int k = 0; k < N_CH; k++) begin
      step();
      sta = 1'b0;
      check_val($sformatf("%s.valid%0d", tag, k), 64'(out_valid), 64'd1);
      check_val($sformatf("%s.addr%0d", tag, k), 64'(out_addr), 64'(k));
      check_val($sformatf("%s.data%0d", tag, k), 64'(out_data), 64'(base + 32'(k)));
      check_val($sformatf("%s.last%0d", tag, k), 64'(out_last), 64'(k == N_CH - 1));
      check_val($sformatf("%s.stale%0d", tag, k), 64'(out_stale), 64'(exp_stale));
    end
    step();
    check_val($sformatf("%s.valid_end", tag), 64'(out_valid), 64'd0);
    check_val($sformatf("%s.busy_end", tag), 64'(rd_busy), 64'd0);
    check_val($sformatf("%s.data_end", tag), 64'(out_data), 64'd0);
    $display("stream %s base 0x%0h stale=%0b", tag, base, exp_stale);
  endtask

  initial begin
    rst = 1'b1;
    sta = 1'b0;
    exchange_req = 1'b0;
    clr_flags = 1'b0;
    in_data = '0;
    do_reset();

    // Reset state
    check_val("rst.valid", 64'(out_valid), 64'd0);
    check_val("rst.data", 64'(out_data), 64'd0);
    check_val("rst.addr", 64'(out_addr), 64'd0);
    check_val("rst.last", 64'(out_last), 64'd0);
    check_val("rst.stale", 64'(out_stale), 64'd0);
    check_val("rst.wr_busy", 64'(wr_busy), 64'd0);
    check_val("rst.rd_busy", 64'(rd_busy), 64'd0);
    check_val("rst.snap_ready", 64'(snap_ready), 64'd0);
    check_val("rst.overrun", 64'(overrun), 64'd0);
    check_val("rst.req_drop", 64'(req_drop), 64'd0);

    // 1: single snapshot, request 10 cycles after sta
    capture(32'h100);                         // now in t0+1
    check_val("t1.wr_busy_first", 64'(wr_busy), 64'd1);
    check_val("t1.ready_early", 64'(snap_ready), 64'd0);
    repeat (7) step();                        // t0+8
    check_val("t1.wr_busy_last", 64'(wr_busy), 64'd1);
    step();                                   // t0+9
    check_val("t1.wr_busy_done", 64'(wr_busy), 64'd0);
    check_val("t1.snap_ready", 64'(snap_ready), 64'd1);
    step();                                   // t0+10
    stream_check("t1", 32'h100, 1'b0, 1'b0);
    check_val("t1.ready_after", 64'(snap_ready), 64'd0);

    // 2: request with no committed snapshot
    do_reset();
    exchange_req = 1'b1;
    step();
    exchange_req = 1'b0;
    check_val("t2.req_drop", 64'(req_drop), 64'd1);
    check_val("t2.rd_busy", 64'(rd_busy), 64'd0);
    step();
    step();
    check_val("t2.no_valid", 64'(out_valid), 64'd0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_val("t2.cleared", 64'(req_drop), 64'd0);
    $display("req without snapshot req_drop cleared");

    // 3: second sta during write is dropped; clr_flags in same cycle loses
    do_reset();
    capture(32'h500);                         // t0+1
    step();
    step();                                   // t0+3
    in_data = make_snap(32'h900);
    sta = 1'b1;
    clr_flags = 1'b1;
    step();                                   // t0+4
    sta = 1'b0;
    clr_flags = 1'b0;
    check_val("t3.overrun", 64'(overrun), 64'd1);
    repeat (5) step();                        // t0+9
    stream_check("t3", 32'h500, 1'b0, 1'b0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_val("t3.overrun_clr", 64'(overrun), 64'd0);

    // 4: request on B's commit cycle streams A; sta into streamed bank dropped
    do_reset();
    capture(32'h100);                         // t0+1
    repeat (8) step();                        // t0+9
    capture(32'h200);                         // t0+10
    repeat (7) step();                        // t0+17, B last write
    check_val("t4.wr_busy", 64'(wr_busy), 64'd1);
    stream_check("t4a", 32'h100, 1'b0, 1'b1);
    check_val("t4.overrun", 64'(overrun), 64'd1);
    check_val("t4.snap_ready", 64'(snap_ready), 64'd1);
    stream_check("t4b", 32'h200, 1'b0, 1'b0);
    capture(32'h300);
    check_val("t4.accept_after", 64'(wr_busy), 64'd1);
    repeat (8) step();
    stream_check("t4c", 32'h300, 1'b0, 1'b0);

    // 5: repeated stream of the same snapshot is marked stale
    do_reset();
    capture(32'h700);
    repeat (8) step();
    stream_check("t5a", 32'h700, 1'b0, 1'b0);
    stream_check("t5b", 32'h700, 1'b1, 1'b0);
    check_val("t5.ready", 64'(snap_ready), 64'd0);

    // 6: reset while word 4 is being written
    do_reset();
    capture(32'h800);                         // t0+1, k=0
    repeat (4) step();                        // t0+5, k=4
    check_val("t6.wr_busy_pre", 64'(wr_busy), 64'd1);
    rst = 1'b1;
    step();
    check_val("t6.wr_busy", 64'(wr_busy), 64'd0);
    check_val("t6.rd_busy", 64'(rd_busy), 64'd0);
    check_val("t6.valid", 64'(out_valid), 64'd0);
    check_val("t6.snap_ready", 64'(snap_ready), 64'd0);
    rst = 1'b0;
    step();
    exchange_req = 1'b1;
    step();
    exchange_req = 1'b0;
    check_val("t6.req_drop", 64'(req_drop), 64'd1);
    step();
    step();
    check_val("t6.no_valid", 64'(out_valid), 64'd0);
    $display("reset mid-write req_drop=%0b", req_drop);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
